// File: rtl/fft2d_cmul_pipe.sv
// Pipelined signed complex multiplier for the 2D-FFT datapath.
// Computes a * b (or a * conj(b) per sample), rescales by FRAC_SHIFT with optional
// round-half-up and saturation, and streams the result over valid/ready.
// All stages advance together on a single enable that drops only when the final
// stage holds a result the consumer has not taken; bubbles are not squeezed out.
module fft2d_cmul_pipe #(
  parameter int unsigned A_W        = 24,
  parameter int unsigned B_W        = 18,
  parameter int unsigned OUT_W      = 24,
  parameter int unsigned FRAC_SHIFT = 17,
  parameter int unsigned NUM_STAGE  = 4,
  parameter bit          ROUND_EN   = 1'b1,
  parameter bit          SAT_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_conj,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   a_re,
  input  logic signed [A_W-1:0]   a_im,
  input  logic signed [B_W-1:0]   b_re,
  input  logic signed [B_W-1:0]   b_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_ovf,
  output logic signed [OUT_W-1:0] p_re,
  output logic signed [OUT_W-1:0] p_im
);

  // Partial product width, full-precision sum width, and rounding headroom width.
  localparam int unsigned PROD_W = A_W + B_W;
  localparam int unsigned P_W    = PROD_W + 1;
  localparam int unsigned X_W    = P_W + 1;
  // Stage 4 plus the pure delay stages that follow it.
  localparam int          DLY    = int'(NUM_STAGE) - 3;

  localparam logic [X_W-1:0]   RND_K   = ROUND_EN ? (X_W'(1) << (FRAC_SHIFT - 1)) : '0;
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Global advance enable
  logic en;

  // Stage 1: registered operands
  logic                  s1_valid_q, s1_conj_q, s1_last_q;
  logic signed [A_W-1:0] a_re_q, a_im_q;
  logic signed [B_W-1:0] b_re_q, b_im_q;

  // Stage 2: partial products
  logic                     s2_valid_q, s2_conj_q, s2_last_q;
  logic signed [PROD_W-1:0] pp_rr_d, pp_ii_d, pp_ri_d, pp_ir_d;
  logic signed [PROD_W-1:0] pp_rr_q, pp_ii_q, pp_ri_q, pp_ir_q;

  // Stage 3: full-precision real/imag sums
  logic           s3_valid_q, s3_last_q;
  logic [P_W-1:0] rr_x, ii_x, ri_x, ir_x;
  logic [P_W-1:0] sum_re_d, sum_im_d;
  logic [P_W-1:0] sum_re_q, sum_im_q;

  // Stage 4 and delay line; index DLY-1 drives the outputs
  logic [OUT_W:0]   sc_re, sc_im;
  logic             vld_q [DLY];
  logic             lst_q [DLY];
  logic             ovf_q [DLY];
  logic [OUT_W-1:0] pre_q [DLY];
  logic [OUT_W-1:0] pim_q [DLY];

  // Round, shift and range-limit one component; returns {overflow, value}.
  function automatic logic [OUT_W:0] rescale(input logic [P_W-1:0] v);
    logic [X_W-1:0]        ext;
    logic signed [X_W-1:0] rnd;
    logic signed [X_W-1:0] sh;
    logic                  ovf;
    logic [OUT_W-1:0]      val;
    ext = {v[P_W-1], v};
    rnd = ext + RND_K;
    sh  = rnd >>> FRAC_SHIFT;
    // In range only when every bit from the output sign bit upward agrees.
    ovf = ~((&sh[X_W-1:OUT_W-1]) | ~(|sh[X_W-1:OUT_W-1]));
    val = sh[OUT_W-1:0];
    if (SAT_EN && ovf) begin
      val = sh[X_W-1] ? OUT_MIN : OUT_MAX;
    end
    return {ovf, val};
  endfunction

  assign en       = ~(vld_q[DLY-1] & ~out_ready);
  assign in_ready = en;

  assign out_valid = vld_q[DLY-1];
  assign out_last  = lst_q[DLY-1];
  assign out_ovf   = ovf_q[DLY-1];
  assign p_re      = pre_q[DLY-1];
  assign p_im      = pim_q[DLY-1];

  // Stage 1: capture operands and sidebands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_conj_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      a_re_q     <= '0;
      a_im_q     <= '0;
      b_re_q     <= '0;
      b_im_q     <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_conj_q  <= in_conj;
      s1_last_q  <= in_last;
      a_re_q     <= a_re;
      a_im_q     <= a_im;
      b_re_q     <= b_re;
      b_im_q     <= b_im;
    end
  end

  // Four signed partial products at exact width
  always_comb begin
    pp_rr_d = PROD_W'(a_re_q) * PROD_W'(b_re_q);
    pp_ii_d = PROD_W'(a_im_q) * PROD_W'(b_im_q);
    pp_ri_d = PROD_W'(a_re_q) * PROD_W'(b_im_q);
    pp_ir_d = PROD_W'(a_im_q) * PROD_W'(b_re_q);
  end

  // Stage 2: register partial products
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_conj_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      pp_rr_q    <= '0;
      pp_ii_q    <= '0;
      pp_ri_q    <= '0;
      pp_ir_q    <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_conj_q  <= s1_conj_q;
      s2_last_q  <= s1_last_q;
      pp_rr_q    <= pp_rr_d;
      pp_ii_q    <= pp_ii_d;
      pp_ri_q    <= pp_ri_d;
      pp_ir_q    <= pp_ir_d;
    end
  end

  // Combine partial products; conj flips the sign of every b_im term
  always_comb begin
    rr_x     = {pp_rr_q[PROD_W-1], pp_rr_q};
    ii_x     = {pp_ii_q[PROD_W-1], pp_ii_q};
    ri_x     = {pp_ri_q[PROD_W-1], pp_ri_q};
    ir_x     = {pp_ir_q[PROD_W-1], pp_ir_q};
    sum_re_d = rr_x - ii_x;
    sum_im_d = ri_x + ir_x;
    if (s2_conj_q) begin
      sum_re_d = rr_x + ii_x;
      sum_im_d = ir_x - ri_x;
    end
  end

  // Stage 3: register full-precision sums
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      sum_re_q   <= '0;
      sum_im_q   <= '0;
    end else if (en) begin
      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      sum_re_q   <= sum_re_d;
      sum_im_q   <= sum_im_d;
    end
  end

  // Rescale both components
  always_comb begin
    sc_re = rescale(sum_re_q);
    sc_im = rescale(sum_im_q);
  end

  // Stage 4 result register followed by the pure delay stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DLY; i++) begin
        vld_q[i] <= 1'b0;
        lst_q[i] <= 1'b0;
        ovf_q[i] <= 1'b0;
        pre_q[i] <= '0;
        pim_q[i] <= '0;
      end
    end else if (en) begin
      vld_q[0] <= s3_valid_q;
      lst_q[0] <= s3_last_q;
      ovf_q[0] <= sc_re[OUT_W] | sc_im[OUT_W];
      pre_q[0] <= sc_re[OUT_W-1:0];
      pim_q[0] <= sc_im[OUT_W-1:0];
      for (int i = 1; i < DLY; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
        pre_q[i] <= pre_q[i-1];
        pim_q[i] <= pim_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft2d_cmul_pipe.sv
// Bench for fft2d_cmul_pipe: two instances (round+saturate, truncate+wrap) share all
// inputs. A queue-based model tracks each accepted sample's age and expected result
// and is compared against both instances on every cycle.
module tb_fft2d_cmul_pipe;

  localparam int A_W   = 24;
  localparam int B_W   = 18;
  localparam int OUT_W = 24;
  localparam int FS    = 17;
  localparam int NS    = 4;

  logic clk;
  logic reset;
  logic in_valid, in_conj, in_last, out_ready;
  logic signed [A_W-1:0] a_re, a_im;
  logic signed [B_W-1:0] b_re, b_im;

  logic in_ready0, out_valid0, out_last0, out_ovf0;
  logic in_ready1, out_valid1, out_last1, out_ovf1;
  logic signed [OUT_W-1:0] p_re0, p_im0, p_re1, p_im1;

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    longint re0, im0, re1, im1;
    bit     ovf0, ovf1, last;
    int     age;
  } exp_t;
  exp_t q[$];

  fft2d_cmul_pipe #(
    .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .FRAC_SHIFT(FS), .NUM_STAGE(NS),
    .ROUND_EN(1'b1), .SAT_EN(1'b1)
  ) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_conj(in_conj), .in_last(in_last), .a_re(a_re), .a_im(a_im),
    .b_re(b_re), .b_im(b_im), .out_valid(out_valid0), .out_ready(out_ready),
    .out_last(out_last0), .out_ovf(out_ovf0), .p_re(p_re0), .p_im(p_im0)
  );

  fft2d_cmul_pipe #(
    .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .FRAC_SHIFT(FS), .NUM_STAGE(NS),
    .ROUND_EN(1'b0), .SAT_EN(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_conj(in_conj), .in_last(in_last), .a_re(a_re), .a_im(a_im),
    .b_re(b_re), .b_im(b_im), .out_valid(out_valid1), .out_ready(out_ready),
    .out_last(out_last1), .out_ovf(out_ovf1), .p_re(p_re1), .p_im(p_im1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scale one full-precision component to OUT_W by plain integer arithmetic.
  function automatic void scale(input longint v, input bit rnd, input bit sat,
                                output longint r, output bit ovf);
    longint s, hi, lo;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (rnd) v = v + (longint'(1) << (FS - 1));
    s   = v >>> FS;
    ovf = (s > hi) || (s < lo);
    if (!ovf) r = s;
    else if (sat) r = (s > hi) ? hi : lo;
    else begin
      r = s & ((longint'(1) << OUT_W) - 1);
      if (r > hi) r = r - (longint'(1) << OUT_W);
    end
  endfunction

  function automatic void cmul_model(input longint ar, input longint ai, input longint br,
                                     input longint bi, input bit conj, input bit rnd,
                                     input bit sat, output longint pr, output longint pi,
                                     output bit ovf);
    longint re, im;
    bit o1, o2;
    re = conj ? (ar * br + ai * bi) : (ar * br - ai * bi);
    im = conj ? (ai * br - ar * bi) : (ar * bi + ai * br);
    scale(re, rnd, sat, pr, o1);
    scale(im, rnd, sat, pi, o2);
    ovf = o1 | o2;
  endfunction

  function automatic longint rnd_s(input int w);
    longint v;
    v = longint'({$urandom(), $urandom()});
    return v >>> (64 - w);
  endfunction

  // Compare process: model of sample ages through a stall-as-a-whole pipeline.
  exp_t e;
  bit   m_valid, m_en;
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      chk("rst_out_valid0", out_valid0, 0);
      chk("rst_out_valid1", out_valid1, 0);
      chk("rst_p_re0", p_re0, 0);
      chk("rst_p_im0", p_im0, 0);
      chk("rst_out_last0", out_last0, 0);
      chk("rst_out_ovf0", out_ovf0, 0);
      chk("rst_p_re1", p_re1, 0);
    end else begin
      m_valid = (q.size() > 0) && (q[0].age == NS);
      m_en    = !(m_valid && !out_ready);
      chk("out_valid0", out_valid0, m_valid);
      chk("out_valid1", out_valid1, m_valid);
      chk("in_ready0", in_ready0, m_en);
      chk("in_ready1", in_ready1, m_en);
      if (m_valid) begin
        chk("p_re0", p_re0, q[0].re0);
        chk("p_im0", p_im0, q[0].im0);
        chk("out_ovf0", out_ovf0, q[0].ovf0);
        chk("out_last0", out_last0, q[0].last);
        chk("p_re1", p_re1, q[0].re1);
        chk("p_im1", p_im1, q[0].im1);
        chk("out_ovf1", out_ovf1, q[0].ovf1);
        chk("out_last1", out_last1, q[0].last);
      end
      if (m_en) begin
        if (m_valid) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (in_valid) begin
          cmul_model(a_re, a_im, b_re, b_im, in_conj, 1'b1, 1'b1, e.re0, e.im0, e.ovf0);
          cmul_model(a_re, a_im, b_re, b_im, in_conj, 1'b0, 1'b0, e.re1, e.im1, e.ovf1);
          e.last = in_last;
          e.age  = 1;
          q.push_back(e);
          n_vec++;
        end
      end
    end
  end

  // Consumer readiness: always ready, or a coin flip each cycle.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input longint ar, input longint ai, input longint br, input longint bi,
                      input bit conj, input bit last);
    bit ok;
    a_re     = ar[A_W-1:0];
    a_im     = ai[A_W-1:0];
    b_re     = br[B_W-1:0];
    b_im     = bi[B_W-1:0];
    in_conj  = conj;
    in_last  = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready0 && reset) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count negedges until dut0 shows a result (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid0 && cyc < 30);
    chk("wait_valid_timeout", out_valid0, 1);
  endtask

  task automatic stream(input int n, input bit fixed_last);
    bit last;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      last = fixed_last ? (i == 9 || i == 19) : ($urandom_range(0, 7) == 0);
      send(rnd_s(A_W), rnd_s(A_W), rnd_s(B_W), rnd_s(B_W), 1'($urandom_range(0, 1)), last);
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    idle(NS + 6);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    longint r, i;
    bit o;
    int c;
    reset = 1'b0; in_valid = 1'b0; in_conj = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;

    // Hand-computed values that pin the reference model itself.
    cmul_model(1000, 0, 65536, 0, 0, 1, 1, r, i, o);
    chk("pin_basic_re", r, 500); chk("pin_basic_im", i, 0); chk("pin_basic_ovf", o, 0);
    cmul_model(100, 200, 65536, 65536, 0, 1, 1, r, i, o);
    chk("pin_cx_re", r, -50); chk("pin_cx_im", i, 150);
    cmul_model(100, 200, 65536, 65536, 1, 1, 1, r, i, o);
    chk("pin_conj_re", r, 150); chk("pin_conj_im", i, 50);
    cmul_model(3, 0, 65536, 0, 0, 1, 1, r, i, o);  chk("pin_rnd_up", r, 2);
    cmul_model(3, 0, 65536, 0, 0, 0, 1, r, i, o);  chk("pin_trunc", r, 1);
    cmul_model(-3, 0, 65536, 0, 0, 1, 1, r, i, o); chk("pin_rnd_neg", r, -1);
    cmul_model(-8388608, -8388608, -131072, 131071, 0, 1, 1, r, i, o);
    chk("pin_sat_re", r, 8388607); chk("pin_sat_im", i, 64); chk("pin_sat_ovf", o, 1);
    cmul_model(-8388608, -8388608, -131072, 131071, 0, 0, 0, r, i, o);
    chk("pin_wrap_re", r, -64); chk("pin_wrap_ovf", o, 1);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic sample right after reset release; check latency.
    send(1000, 0, 65536, 0, 0, 0);
    wait_valid(c);
    chk("basic_latency", c - 1, NS - 1);
    chk("basic_p_re", p_re0, 500); chk("basic_p_im", p_im0, 0); chk("basic_ovf", out_ovf0, 0);
    idle(1);

    // Complex then conjugate, back to back.
    send(100, 200, 65536, 65536, 0, 0);
    send(100, 200, 65536, 65536, 1, 0);
    wait_valid(c);
    chk("cx_p_re", p_re0, -50); chk("cx_p_im", p_im0, 150);
    @(negedge clk);
    chk("conj_consecutive", out_valid0, 1);
    chk("conj_p_re", p_re0, 150); chk("conj_p_im", p_im0, 50);
    idle(1);

    // Rounding versus truncation.
    send(3, 0, 65536, 0, 0, 0);
    wait_valid(c);
    chk("rnd_p_re0", p_re0, 2); chk("trunc_p_re1", p_re1, 1);
    idle(1);
    send(-3, 0, 65536, 0, 0, 0);
    wait_valid(c);
    chk("rnd_neg_p_re0", p_re0, -1);
    idle(1);

    // Saturation versus wrap.
    send(-8388608, -8388608, -131072, 131071, 0, 0);
    wait_valid(c);
    chk("sat_p_re0", p_re0, 8388607); chk("sat_p_im0", p_im0, 64); chk("sat_ovf0", out_ovf0, 1);
    chk("wrap_p_re1", p_re1, -64); chk("wrap_ovf1", out_ovf1, 1);
    idle(1);

    // Backpressure: 20 random samples, last on #9 and #19.
    rand_ready = 1'b1;
    stream(20, 1'b1);
    drain();

    // Reset in the middle of a stream.
    idle(1);
    send(1000, 7, 65536, 3, 0, 1);
    send(2000, 9, 65536, 5, 1, 0);
    send(3000, 11, 65536, 7, 0, 1);
    @(posedge clk);
    #1;
    chk("rm_pre_valid", out_valid0, 1);
    reset = 1'b0;
    #1;
    chk("rm_now_valid0", out_valid0, 0); chk("rm_now_valid1", out_valid1, 0);
    chk("rm_now_p_re0", p_re0, 0); chk("rm_now_p_im0", p_im0, 0);
    chk("rm_now_last0", out_last0, 0); chk("rm_now_ovf0", out_ovf0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rm_quiet", out_valid0 | out_valid1, 0);
    end
    @(posedge clk);
    #1;
    send(1234, -567, 40000, -30000, 1, 0);
    wait_valid(c);
    chk("rm_latency", c - 1, NS - 1);
    idle(1);

    // Long randomized run with random stalls and frame markers.
    rand_ready = 1'b1;
    stream(300, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft2d_cmul_pipe.md
# fft2d_cmul_pipe

Pipelined, parametrised signed complex multiplier for the 2D-FFT datapath: multiplies a complex sample by a complex twiddle factor, rescales the product by a fixed fractional shift with selectable rounding and saturation, and delivers the result through a valid/ready stream interface with full backpressure. It sits between the butterfly stages of the FFT kernel. It generalises the existing fixed 24s×18s four-stage real multiplier: configurable widths and depth, complex operands, a conjugate mode, an overflow flag and a frame-marker pass-through.

## Interface
- A_W, 24, signed width of sample components (a_re, a_im)
- B_W, 18, signed width of twiddle components (b_re, b_im)
- OUT_W, 24, signed width of result components
- FRAC_SHIFT, 17, arithmetic right shift applied to the full-precision product; range 1..A_W+B_W-1
- NUM_STAGE, 4, total latency in cycles; minimum 4
- ROUND_EN, 1, 1 = round half up before shift, 0 = truncate toward −∞
- SAT_EN, 1, 1 = saturate to OUT_W, 0 = wrap (keep low OUT_W bits)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input this cycle
- in_conj  in  1  per-sample: 1 = multiply by conj(b)
- in_last  in  1  frame marker, passed through aligned with data
- a_re, a_im  in  A_W each  sample
- b_re, b_im  in  B_W each  twiddle
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_last  out  1  delayed in_last
- out_ovf  out  1  saturation/wrap occurred on either component of this result
- p_re, p_im  out  OUT_W each  result

## Operation
- Full precision P_W = A_W+B_W+1.
- Normal: re = a_re·b_re − a_im·b_im; im = a_re·b_im + a_im·b_re.
- Conj (in_conj=1): re = a_re·b_re + a_im·b_im; im = a_im·b_re − a_re·b_im.
- Rescale: if ROUND_EN, add 2^(FRAC_SHIFT−1) in P_W+1 bits, then arithmetic shift right by FRAC_SHIFT.
- SAT_EN=1: clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. SAT_EN=0: take the low OUT_W bits.
- out_ovf=1 iff the shifted value of either component lies outside the OUT_W range. The flag is computed identically in both SAT_EN modes.
- Pipeline stages, each carrying a valid bit plus the conj and last sidebands:
  - S1: register operands.
  - S2: four partial products.
  - S3: add/subtract.
  - S4: round, shift, saturate.
  - Stages 5..NUM_STAGE: pure delay registers.
- Advance enable: en = ~(v_last & ~out_ready), where v_last is the valid bit of the final stage. When en=0, every stage holds.
- in_ready = en. A sample is accepted when in_valid & in_ready.
- Bubbles are not compressed. Valid bits shift with data, so empty stages persist while stalled.

## Timing
- Reset (reset=0, asynchronous): all valid bits, out_valid, out_last, out_ovf, p_re and p_im go to 0. Data registers may also clear.
- Deassertion: the first acceptance can occur in the first cycle after reset rises.
- Latency: a sample accepted at edge k appears with out_valid=1 after edge k+NUM_STAGE−1, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 sample/cycle while out_ready=1.
- Output hold: out_valid & ~out_ready holds p_*, out_last and out_ovf stable. in_ready is 0 in the same cycle, combinationally.
- Output stability: out_valid never drops without a handshake.
- out_ready=1 with no output valid: the pipeline flows and in_ready=1.
- Reset mid-stream: all in-flight samples are discarded. No output is produced for them after reset releases.
- Sidebands (in_last, in_conj): travel in lockstep with their sample. No cross-sample mixing is allowed under any stall pattern.

## Test plan
- Basic (defaults, conj=0): a=(1000,0), b=(65536,0), out_ready=1 → p=(500,0), ovf=0. out_valid rises exactly 3 cycles after the accept edge (NUM_STAGE=4).
- Complex and conj: a=(100,200), b=(65536,65536).
  - conj=0 → p=(−50,150).
  - Next sample, same operands, conj=1 → p=(150,50).
  - Results arrive on consecutive cycles.
- Rounding: a=(3,0), b=(65536,0).
  - ROUND_EN=1 → p_re=2.
  - ROUND_EN=0 → p_re=1.
  - a=(−3,0), ROUND_EN=1 → p_re=−1.
- Saturation: a=(−8388608,−8388608), b=(−131072,131071).
  - SAT_EN=1 → p_re=8388607, p_im=64, ovf=1.
  - SAT_EN=0 → p_re=16777152 mod 2^24 = −64 (signed), ovf=1.
- Backpressure: stream 20 random samples with in_last on #9 and #19, with out_ready toggled pseudo-randomly (~50%). The output sequence must match the reference model in order, with out_last on #9 and #19. Outputs stay stable while stalled, and in_ready is 0 exactly when the output is valid and out_ready=0.
- Reset mid-stream: load 3 samples, assert reset for 1 cycle.
  - Outputs go to 0 immediately.
  - No out_valid occurs for 10 cycles after release.
  - A new sample then produces a correct result at the normal latency.
